io_bank_ctrl: RTL and testbench

//  Parametrised N-bank IO controller; successor to the fixed two-bank IO logic in the top level.
//  - Holds per-bank direction and output registers, updated under a bit mask.
//  - Synchronises IO inputs for bank read-back.
//  - Adds a timed pulse mode: drive masked bits for N clocks, then restore them.
//  - Sits between pkt_decode (command/response side) and the IO pad tristates.

---
 rtl/io_bank_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_io_bank_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : io_bank_ctrl
// Brief   : N-bank IO controller: masked dir/data writes, synchronised read-back, timed pulses.
// Revision: 1.0
// ============================================================================
module io_bank_ctrl #(
   parameter int NUM_BANKS  = 4,
   parameter int BANK_NBIT  = 2,
   parameter int UNIT_NBIT  = 16,
   parameter int PULSE_NBIT = 16,
   parameter logic [NUM_BANKS*UNIT_NBIT-1:0] RST_DIR = '0,
   parameter logic [NUM_BANKS*UNIT_NBIT-1:0] RST_DB  = '0
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           cmd_vd,
   output logic                           cmd_rdy,
   input  logic [1:0]                     cmd_op,
   input  logic [BANK_NBIT-1:0]           cmd_bank,
   input  logic [UNIT_NBIT-1:0]           cmd_mask,
   input  logic [UNIT_NBIT-1:0]           cmd_dir,
   input  logic [UNIT_NBIT-1:0]           cmd_db,
   input  logic [PULSE_NBIT-1:0]          cmd_len,
   output logic                           rsp_vd,
   output logic                           rsp_err,
   output logic [UNIT_NBIT-1:0]           rsp_db,
   output logic [NUM_BANKS*UNIT_NBIT-1:0] io_dir,
   output logic [NUM_BANKS*UNIT_NBIT-1:0] io_do,
   input  logic [NUM_BANKS*UNIT_NBIT-1:0] io_di,
   output logic [NUM_BANKS-1:0]           pulse_act
);

   localparam logic [1:0] c_OP_WRITE = 2'd0;
   localparam logic [1:0] c_OP_READ  = 2'd1;
   localparam logic [1:0] c_OP_PULSE = 2'd2;
   localparam logic [1:0] c_OP_RSVD  = 2'd3;
   localparam logic [BANK_NBIT:0] c_NBANKS = (BANK_NBIT+1)'(NUM_BANKS);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RD_CAP = 2'd1,
      S_RD_RSP = 2'd2
   } state_t;

   state_t                         r_state;
   state_t                         w_state_nxt;
   logic                           w_acc;
   logic                           w_err;
   logic                           w_bank_ok;
   logic                           w_is_read_ok;
   logic [NUM_BANKS-1:0]           w_sel;
   logic [NUM_BANKS-1:0]           w_ovl;
   logic [NUM_BANKS-1:0]           w_act;
   logic                           r_rsp_vd;
   logic                           r_rsp_err;
   logic [UNIT_NBIT-1:0]           r_rd_q;
   logic [BANK_NBIT-1:0]           r_rd_bank;
   logic [UNIT_NBIT-1:0]           w_sync_bank;
   logic [NUM_BANKS*UNIT_NBIT-1:0] r_sync1;
   logic [NUM_BANKS*UNIT_NBIT-1:0] r_sync2;

   logic [UNIT_NBIT-1:0]  r_dir   [NUM_BANKS];
   logic [UNIT_NBIT-1:0]  r_do    [NUM_BANKS];
   logic [UNIT_NBIT-1:0]  r_pmask [NUM_BANKS];
   logic [UNIT_NBIT-1:0]  r_psave [NUM_BANKS];
   logic [PULSE_NBIT-1:0] r_cnt   [NUM_BANKS];
   logic                  r_pact  [NUM_BANKS];

   assign w_acc     = cmd_vd & (r_state == S_IDLE);
   assign w_bank_ok = {1'b0, cmd_bank} < c_NBANKS;

   // w_sel is all-zero for an out-of-range bank, so the per-bank terms vanish
   assign w_err = ~w_bank_ok
                | (cmd_op == c_OP_RSVD)
                | ((cmd_op == c_OP_PULSE) & ((cmd_len == '0) | (|(w_sel & w_act))))
                | ((cmd_op == c_OP_WRITE) & (|(w_sel & w_ovl)));

   assign w_is_read_ok = (cmd_op == c_OP_READ) & ~w_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      cmd_rdy     = 1'b0;
      rsp_vd      = r_rsp_vd;
      rsp_db      = '0;
      case (r_state)
         S_IDLE: begin
            cmd_rdy = 1'b1;
            if (w_acc && w_is_read_ok) begin
               w_state_nxt = S_RD_CAP;
            end
         end
         S_RD_CAP: begin
            w_state_nxt = S_RD_RSP;
         end
         S_RD_RSP: begin
            rsp_vd      = 1'b1;
            rsp_db      = r_rd_q;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign rsp_err = r_rsp_err;

   // Successful READs respond from the FSM instead of this strobe
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rsp_vd  <= 1'b0;
         r_rsp_err <= 1'b0;
         r_rd_bank <= '0;
         r_rd_q    <= '0;
         r_sync1   <= '0;
         r_sync2   <= '0;
      end else begin
         r_rsp_vd  <= w_acc & ~w_is_read_ok;
         r_rsp_err <= w_acc & w_err;
         r_sync1   <= io_di;
         r_sync2   <= r_sync1;
         if (w_acc && w_is_read_ok) begin
            r_rd_bank <= cmd_bank;
         end
         if (r_state == S_RD_CAP) begin
            r_rd_q <= w_sync_bank;
         end
      end
   end

   always_comb begin
      w_sync_bank = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         if (r_rd_bank == BANK_NBIT'(b)) begin
            w_sync_bank = r_sync2[b*UNIT_NBIT +: UNIT_NBIT];
         end
      end
   end

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      localparam logic [BANK_NBIT-1:0] c_IDX = BANK_NBIT'(b);

      logic                 w_wr;
      logic                 w_pl;
      logic                 w_exp;
      logic [UNIT_NBIT-1:0] w_do_base;

      assign w_sel[b] = (cmd_bank == c_IDX);
      assign w_act[b] = r_pact[b];
      assign w_ovl[b] = r_pact[b] & (|(cmd_mask & r_pmask[b]));
      assign w_wr     = w_acc & ~w_err & (cmd_op == c_OP_WRITE) & w_sel[b];
      assign w_pl     = w_acc & ~w_err & (cmd_op == c_OP_PULSE) & w_sel[b];
      assign w_exp    = r_pact[b] & (r_cnt[b] == PULSE_NBIT'(1));

      // Restore happens first so a same-cycle non-overlapping WRITE also lands
      assign w_do_base = w_exp ? ((r_do[b] & ~r_pmask[b]) | r_psave[b]) : r_do[b];

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_dir[b]   <= RST_DIR[b*UNIT_NBIT +: UNIT_NBIT];
            r_do[b]    <= RST_DB[b*UNIT_NBIT +: UNIT_NBIT];
            r_pmask[b] <= '0;
            r_psave[b] <= '0;
            r_cnt[b]   <= '0;
            r_pact[b]  <= 1'b0;
         end else begin
            if (w_wr) begin
               r_dir[b] <= (r_dir[b] & ~cmd_mask) | (cmd_dir & cmd_mask);
            end else if (w_pl) begin
               r_dir[b] <= r_dir[b] | cmd_mask;
            end

            if (w_wr || w_pl) begin
               r_do[b] <= (w_do_base & ~cmd_mask) | (cmd_db & cmd_mask);
            end else begin
               r_do[b] <= w_do_base;
            end

            if (w_pl) begin
               r_cnt[b]   <= cmd_len;
               r_pmask[b] <= cmd_mask;
               r_psave[b] <= r_do[b] & cmd_mask;
               r_pact[b]  <= 1'b1;
            end else if (r_pact[b]) begin
               r_cnt[b] <= r_cnt[b] - PULSE_NBIT'(1);
               if (w_exp) begin
                  r_pact[b] <= 1'b0;
               end
            end
         end
      end

      assign io_dir[b*UNIT_NBIT +: UNIT_NBIT] = r_dir[b];
      assign io_do[b*UNIT_NBIT +: UNIT_NBIT]  = r_do[b];
      assign pulse_act[b]                     = r_pact[b];
   end

endmodule
`default_nettype wire

// File: tb/tb_io_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_io_bank_ctrl
// Brief   : Directed bench for io_bank_ctrl with a per-cycle behavioural reference.
// Revision: 1.0
// ============================================================================
module tb_io_bank_ctrl;

   localparam int NB = 4;
   localparam int BW = 3;
   localparam int UW = 16;
   localparam int PW = 16;
   localparam int W  = NB*UW;
   localparam logic [W-1:0] P_RST_DIR = '0;
   localparam logic [W-1:0] P_RST_DB  = 64'h0000_0000_0000_0001;

   logic          clk;
   logic          rst_n;
   logic          cmd_vd;
   logic          cmd_rdy;
   logic [1:0]    cmd_op;
   logic [BW-1:0] cmd_bank;
   logic [UW-1:0] cmd_mask;
   logic [UW-1:0] cmd_dir;
   logic [UW-1:0] cmd_db;
   logic [PW-1:0] cmd_len;
   logic          rsp_vd;
   logic          rsp_err;
   logic [UW-1:0] rsp_db;
   logic [W-1:0]  io_dir;
   logic [W-1:0]  io_do;
   logic [W-1:0]  io_di;
   logic [NB-1:0] pulse_act;

   int n_cmp = 0;
   int n_bad = 0;

   io_bank_ctrl #(
      .NUM_BANKS (NB),
      .BANK_NBIT (BW),
      .UNIT_NBIT (UW),
      .PULSE_NBIT(PW),
      .RST_DIR   (P_RST_DIR),
      .RST_DB    (P_RST_DB)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .cmd_vd   (cmd_vd),
      .cmd_rdy  (cmd_rdy),
      .cmd_op   (cmd_op),
      .cmd_bank (cmd_bank),
      .cmd_mask (cmd_mask),
      .cmd_dir  (cmd_dir),
      .cmd_db   (cmd_db),
      .cmd_len  (cmd_len),
      .rsp_vd   (rsp_vd),
      .rsp_err  (rsp_err),
      .rsp_db   (rsp_db),
      .io_dir   (io_dir),
      .io_do    (io_do),
      .io_di    (io_di),
      .pulse_act(pulse_act)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference state: bank registers, remaining pulse cycles, read pipeline depth
   logic [UW-1:0] m_dir   [NB];
   logic [UW-1:0] m_do    [NB];
   logic [UW-1:0] m_pmask [NB];
   logic [UW-1:0] m_psave [NB];
   int            m_rem   [NB];
   int            m_busy;
   int            m_rdb;
   logic          m_vd;
   logic          m_err;
   logic [UW-1:0] m_db;
   logic [W-1:0]  m_s1;
   logic [W-1:0]  m_s2;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int b = 0; b < NB; b++) begin
         m_dir[b]   = P_RST_DIR[b*UW +: UW];
         m_do[b]    = P_RST_DB[b*UW +: UW];
         m_pmask[b] = '0;
         m_psave[b] = '0;
         m_rem[b]   = 0;
      end
      m_busy = 0;
      m_rdb  = 0;
      m_vd   = 1'b0;
      m_err  = 1'b0;
      m_db   = '0;
      m_s1   = '0;
      m_s2   = '0;
   endtask

   task automatic model_step();
      logic [W-1:0] s2_old;
      bit           pre [NB];
      bit           err;
      bit           do_wr;
      bit           do_pl;
      int           bk;
      s2_old = m_s2;
      m_s2   = m_s1;
      m_s1   = io_di;
      for (int b = 0; b < NB; b++) pre[b] = (m_rem[b] != 0);
      m_vd  = 1'b0;
      m_err = 1'b0;
      m_db  = '0;
      do_wr = 1'b0;
      do_pl = 1'b0;
      bk    = int'(cmd_bank);
      if (m_busy == 1) begin
         m_busy = 0;
      end else if (m_busy == 2) begin
         m_busy = 1;
         m_vd   = 1'b1;
         m_db   = s2_old[m_rdb*UW +: UW];
      end else if (cmd_vd) begin
         err = (bk >= NB) || (cmd_op == 2'd3)
            || (cmd_op == 2'd2 && (cmd_len == 0 || pre[bk]))
            || (cmd_op == 2'd0 && pre[bk] && ((cmd_mask & m_pmask[bk]) != 0));
         if (err) begin
            m_vd  = 1'b1;
            m_err = 1'b1;
         end else if (cmd_op == 2'd1) begin
            m_busy = 2;
            m_rdb  = bk;
         end else begin
            m_vd  = 1'b1;
            do_wr = (cmd_op == 2'd0);
            do_pl = (cmd_op == 2'd2);
         end
      end
      for (int b = 0; b < NB; b++) begin
         if (pre[b]) begin
            m_rem[b]--;
            if (m_rem[b] == 0) m_do[b] = (m_do[b] & ~m_pmask[b]) | m_psave[b];
         end
      end
      if (do_wr) begin
         m_dir[bk] = (m_dir[bk] & ~cmd_mask) | (cmd_dir & cmd_mask);
         m_do[bk]  = (m_do[bk] & ~cmd_mask) | (cmd_db & cmd_mask);
      end
      if (do_pl) begin
         m_psave[bk] = m_do[bk] & cmd_mask;
         m_pmask[bk] = cmd_mask;
         m_dir[bk]   = m_dir[bk] | cmd_mask;
         m_do[bk]    = (m_do[bk] & ~cmd_mask) | (cmd_db & cmd_mask);
         m_rem[bk]   = int'(cmd_len);
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) model_reset();
      else        model_step();
   end

   always @(negedge clk) begin
      logic [W-1:0]  e_dir;
      logic [W-1:0]  e_do;
      logic [NB-1:0] e_act;
      for (int b = 0; b < NB; b++) begin
         e_dir[b*UW +: UW] = m_dir[b];
         e_do[b*UW +: UW]  = m_do[b];
         e_act[b]          = (m_rem[b] != 0);
      end
      chk("io_dir", io_dir, e_dir);
      chk("io_do", io_do, e_do);
      chk("pulse_act", 64'(pulse_act), 64'(e_act));
      chk("rsp_vd", 64'(rsp_vd), 64'(m_vd));
      chk("rsp_err", 64'(rsp_err), 64'(m_err));
      chk("rsp_db", 64'(rsp_db), 64'(m_db));
      chk("cmd_rdy", 64'(cmd_rdy), 64'(m_busy == 0));
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic cmd(input logic [1:0] op, input int bank, input logic [UW-1:0] mask,
                      input logic [UW-1:0] dir, input logic [UW-1:0] db, input int len);
      cmd_vd   = 1'b1;
      cmd_op   = op;
      cmd_bank = BW'(bank);
      cmd_mask = mask;
      cmd_dir  = dir;
      cmd_db   = db;
      cmd_len  = PW'(len);
      @(negedge clk);
      #1;
      cmd_vd = 1'b0;
   endtask

   initial begin
      model_reset();
      rst_n    = 1'b0;
      cmd_vd   = 1'b0;
      cmd_op   = '0;
      cmd_bank = '0;
      cmd_mask = '0;
      cmd_dir  = '0;
      cmd_db   = '0;
      cmd_len  = '0;
      io_di    = '0;
      idle(2);
      chk("rst_do0", 64'(io_do[0]), 64'd1);
      chk("rst_rsp_vd", 64'(rsp_vd), 64'd0);
      rst_n = 1'b1;
      idle(1);
      chk("rdy_after_rst", 64'(cmd_rdy), 64'd1);

      // Masked write over prior data 0x000F
      cmd(2'd0, 1, 16'h000F, 16'h0000, 16'h000F, 0);
      cmd(2'd0, 1, 16'h00F0, 16'hFFFF, 16'h0050, 0);
      chk("wr_dir_b1", 64'(io_dir[31:16]), 64'h00F0);
      chk("wr_do_b1", 64'(io_do[31:16]), 64'h005F);
      chk("wr_rsp_err", 64'(rsp_err), 64'd0);

      // Read-back through the synchroniser; a command during the busy cycle is ignored
      io_di = {16'h0000, 16'hA5A5, 32'h0};
      idle(3);
      cmd(2'd1, 2, 16'h0, 16'h0, 16'h0, 0);
      chk("rd_rdy_low1", 64'(cmd_rdy), 64'd0);
      chk("rd_no_early_vd", 64'(rsp_vd), 64'd0);
      cmd(2'd0, 0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 0);
      chk("rd_rsp_vd", 64'(rsp_vd), 64'd1);
      chk("rd_rsp_db", 64'(rsp_db), 64'hA5A5);
      chk("rd_rdy_low2", 64'(cmd_rdy), 64'd0);
      idle(1);
      chk("rd_rdy_back", 64'(cmd_rdy), 64'd1);

      // Pulse bank0 bit0 for 5 cycles with overlapping / disjoint writes during it
      cmd(2'd0, 0, 16'h0001, 16'h0000, 16'h0000, 0);
      cmd(2'd2, 0, 16'h0001, 16'h0000, 16'h0001, 5);
      chk("pl_do_c1", 64'(io_do[0]), 64'd1);
      chk("pl_act_c1", 64'(pulse_act[0]), 64'd1);
      cmd(2'd0, 0, 16'h0001, 16'h0000, 16'h0000, 0);
      chk("pl_ovl_err", 64'(rsp_err), 64'd1);
      cmd(2'd0, 0, 16'h0002, 16'h0002, 16'h0002, 0);
      chk("pl_dis_err", 64'(rsp_err), 64'd0);
      idle(2);
      chk("pl_do_c5", 64'(io_do[0]), 64'd1);
      chk("pl_act_c5", 64'(pulse_act[0]), 64'd1);
      idle(1);
      chk("pl_do_end", 64'(io_do[1:0]), 64'h2);
      chk("pl_act_end", 64'(pulse_act[0]), 64'd0);
      chk("pl_dir_end", 64'(io_dir[1:0]), 64'h3);

      // Concurrent pulses on two banks
      cmd(2'd2, 2, 16'hFF00, 16'h0, 16'hAA00, 3);
      cmd(2'd2, 1, 16'h0F00, 16'h0, 16'h0F00, 2);
      chk("conc_act", 64'(pulse_act), 64'h6);
      idle(4);

      // New pulse on the expiry cycle is rejected
      cmd(2'd2, 3, 16'h0001, 16'h0, 16'h0001, 1);
      cmd(2'd2, 3, 16'h0001, 16'h0, 16'h0001, 1);
      chk("exp_repulse_err", 64'(rsp_err), 64'd1);
      idle(1);

      // Restore and disjoint write on the same edge
      cmd(2'd2, 3, 16'h0001, 16'h0, 16'h0001, 2);
      idle(1);
      cmd(2'd0, 3, 16'h0010, 16'h0010, 16'h0010, 0);
      chk("exp_wr_do_b3", 64'(io_do[63:48]), 64'h0010);
      idle(1);

      // Error cases
      cmd(2'd0, 5, 16'hFFFF, 16'hFFFF, 16'hFFFF, 0);
      chk("err_bank", 64'(rsp_err), 64'd1);
      cmd(2'd3, 0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 0);
      chk("err_op3", 64'(rsp_err), 64'd1);
      cmd(2'd2, 0, 16'h0001, 16'h0, 16'h0001, 0);
      chk("err_len0", 64'(rsp_err), 64'd1);
      cmd(2'd1, 6, 16'h0, 16'h0, 16'h0, 0);
      chk("err_read", 64'(rsp_err), 64'd1);
      chk("err_read_rdy", 64'(cmd_rdy), 64'd1);
      idle(1);

      // Reset in the middle of a pulse
      cmd(2'd2, 0, 16'hFFFF, 16'h0, 16'h1234, 10);
      idle(2);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_do", io_do, P_RST_DB);
      chk("rst_mid_act", 64'(pulse_act), 64'd0);
      idle(2);
      chk("rst_mid_vd", 64'(rsp_vd), 64'd0);
      rst_n = 1'b1;
      idle(1);

      // Reset in the middle of a read
      cmd(2'd1, 2, 16'h0, 16'h0, 16'h0, 0);
      rst_n = 1'b0;
      idle(2);
      chk("rst_rd_vd", 64'(rsp_vd), 64'd0);
      rst_n = 1'b1;
      idle(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
